// File: rtl/mem_dump_scanner.sv
// rtl/mem_dump_scanner.sv - windowed memory-dump address sequencer with valid/ready handshake
//
// Walks [start_addr..end_addr] in steps of stride, presenting each address
// under a valid/ready handshake. After acceptance, the address is held for
// dwell extra cycles. The scan runs one-shot or wraps back to start_addr.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, stop         scan start pulse (honoured when idle/done), abort to idle
//   mode_wrap           1 = restart at start_addr after the window end, 0 = one-shot
//   start_addr,end_addr inclusive scan window, sampled on the accepted start
//   stride              address increment (0 behaves as 1), sampled on start
//   dwell               hold cycles after each acceptance, sampled at acceptance
//   dump_ready          consumer accepts the current address
//   dump_addr/valid     current address and its qualifier
//   busy, done          scan in progress / one-shot scan finished (level)
//   wrapped             one-cycle pulse when the address returns to start_addr
//   beat_cnt            accepted addresses since the last start
module mem_dump_scanner #(
  parameter int ADDR_W  = 16,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_wrap,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic [ADDR_W-1:0]  stride,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dump_ready,
  output logic [ADDR_W-1:0]  dump_addr,
  output logic               dump_valid,
  output logic               busy,
  output logic               done,
  output logic               wrapped,
  output logic [ADDR_W-1:0]  beat_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_DWELL   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W-1:0]  ONE_A = 1;
  localparam logic [DWELL_W-1:0] ONE_D = 1;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  start_l;
  logic [ADDR_W-1:0]  end_l;
  logic [ADDR_W-1:0]  stride_l;
  logic               wrap_l;
  logic [DWELL_W-1:0] dwell_cnt;

  // One extra bit so a step past the top of the address space is seen as
  // leaving the window instead of silently wrapping to a low address.
  logic [ADDR_W:0]    next_addr;
  logic               exhausted;

  assign next_addr = {1'b0, dump_addr} + {1'b0, stride_l};
  assign exhausted = next_addr > {1'b0, end_l};

  // Where the scan goes when it leaves the current address; shared by the
  // zero-dwell path in PRESENT and the dwell-expiry path in DWELL.
  logic [1:0]        adv_state;
  logic [ADDR_W-1:0] adv_addr;
  logic              adv_wrap;

  always_comb begin
    adv_state = S_PRESENT;
    adv_addr  = next_addr[ADDR_W-1:0];
    adv_wrap  = 1'b0;
    if (exhausted) begin
      if (wrap_l) begin
        adv_addr = start_l;
        adv_wrap = 1'b1;
      end else begin
        adv_state = S_DONE;
        adv_addr  = dump_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      start_l    <= '0;
      end_l      <= '0;
      stride_l   <= '0;
      wrap_l     <= 1'b0;
      dwell_cnt  <= '0;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      wrapped <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        dump_valid <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              start_l    <= start_addr;
              end_l      <= end_addr;
              stride_l   <= (stride == '0) ? ONE_A : stride;
              wrap_l     <= mode_wrap;
              dump_addr  <= start_addr;
              beat_cnt   <= '0;
              done       <= 1'b0;
              busy       <= 1'b1;
              dump_valid <= 1'b1;
              state      <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            if (dump_ready) begin
              beat_cnt <= beat_cnt + ONE_A;
              if (dwell == '0) begin
                state      <= adv_state;
                dump_addr  <= adv_addr;
                wrapped    <= adv_wrap;
                dump_valid <= (adv_state == S_PRESENT);
                busy       <= (adv_state == S_PRESENT);
                done       <= (adv_state == S_DONE);
              end else begin
                dwell_cnt  <= dwell;
                dump_valid <= 1'b0;
                state      <= S_DWELL;
              end
            end
          end
          S_DWELL: begin
            dwell_cnt <= dwell_cnt - ONE_D;
            if (dwell_cnt == ONE_D) begin
              state      <= adv_state;
              dump_addr  <= adv_addr;
              wrapped    <= adv_wrap;
              dump_valid <= (adv_state == S_PRESENT);
              busy       <= (adv_state == S_PRESENT);
              done       <= (adv_state == S_DONE);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_scanner.sv
// tb/tb_mem_dump_scanner.sv - scoreboard bench for mem_dump_scanner
module tb_mem_dump_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_wrap = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [15:0] stride = '0;
  logic [7:0]  dwell = '0;
  logic        dump_ready = 1'b0;
  logic [15:0] dump_addr;
  logic        dump_valid;
  logic        busy;
  logic        done;
  logic        wrapped;
  logic [15:0] beat_cnt;

  mem_dump_scanner #(.ADDR_W(16), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_wrap(mode_wrap),
    .start_addr(start_addr), .end_addr(end_addr), .stride(stride), .dwell(dwell),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .busy(busy), .done(done), .wrapped(wrapped), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_q[$];
  int beats_seen = 0;
  int target = 0;
  int wraps_seen = 0;
  int cur_dwell = 0;
  logic [15:0] exp_start = '0;
  bit mon_en = 1'b0;
  int rdy_ctl = 2;   // 0: ready until target, 1: random until target, 2: forced 1, 3: forced 0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Ready driver: stops offering ready once the scoreboard has all beats it expects.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_ctl)
        0: dump_ready = (beats_seen < target);
        1: dump_ready = (beats_seen < target) && ($urandom_range(0, 1) == 1);
        2: dump_ready = 1'b1;
        default: dump_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the expected address on each handshake, checks dwell gaps and wrap pulses.
  bit armed = 1'b0;
  int gap = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (armed) begin
        if (dump_valid) begin
          chk("dwell_gap", gap, cur_dwell);
          armed = 1'b0;
        end else if (!busy) armed = 1'b0;
        else gap++;
      end
      if (wrapped) begin
        if (beats_seen < target) wraps_seen++;
        chk("wrap_addr", dump_addr, exp_start);
        chk("wrap_valid", dump_valid, 1);
      end
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat_addr", dump_addr, exp_q.pop_front());
        chk("beat_cnt_run", beat_cnt, beats_seen);
        beats_seen++;
        armed = 1'b1;
        gap = 0;
      end
    end
  end

  task automatic run_scan(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                          input logic [7:0] dw, input bit wr, input int rmode);
    logic [15:0] win[$];
    int a, n, st_eff, len, k, waited;
    st_eff = (st == 0) ? 1 : int'(st);
    a = int'(s);
    win.push_back(s);
    forever begin
      n = a + st_eff;
      if (n > int'(e)) break;
      a = n;
      win.push_back(a[15:0]);
    end
    len = win.size();
    k = wr ? 2 * len + 1 : len;
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back(win[i % len]);
    exp_start = s;
    cur_dwell = int'(dw);
    beats_seen = 0;
    wraps_seen = 0;
    target = k;
    rdy_ctl = rmode;
    mon_en = 1'b1;

    @(posedge clk); #1;
    start_addr = s; end_addr = e; stride = st; dwell = dw; mode_wrap = wr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scrambled inputs must not affect a scan already latched.
    start_addr = 16'($urandom); end_addr = 16'($urandom); stride = 16'($urandom); mode_wrap = ~wr;

    waited = 0;
    while (beats_seen < k && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (beats_seen < k) chk("beat_timeout", beats_seen, k);

    if (!wr) begin
      waited = 0;
      while (!done && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", dump_valid, 0);
      chk("done_beats", beat_cnt, k);
      chk("done_last_addr", dump_addr, win[len-1]);
      chk("oneshot_wraps", wraps_seen, 0);
    end else begin
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      chk("stop_busy", busy, 0);
      chk("stop_valid", dump_valid, 0);
      chk("stop_done", done, 0);
      chk("stop_beats", beat_cnt, k);
      chk("wrap_count", wraps_seen, (k - 1) / len);
    end
    chk("queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    logic [15:0] s, e;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_addr", dump_addr, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat", beat_cnt, 0);
    reset = 1'b0;

    // Reset arriving mid-scan clears outputs before the next edge.
    rdy_ctl = 2;
    @(posedge clk); #1;
    start_addr = 16'h0040; end_addr = 16'h00FF; stride = 16'd1; dwell = 8'd0; mode_wrap = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_addr", dump_addr, 0);
    chk("async_rst_valid", dump_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_beat", beat_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed windows.
    run_scan(16'h0010, 16'h0013, 16'h0000, 8'd0, 1'b0, 0);
    run_scan(16'h0000, 16'h0009, 16'h0004, 8'd0, 1'b1, 0);
    run_scan(16'h0030, 16'h0036, 16'h0002, 8'd3, 1'b0, 1);
    run_scan(16'hFFFE, 16'hFFFF, 16'h0003, 8'd0, 1'b0, 0);
    run_scan(16'h0020, 16'h0010, 16'h0001, 8'd0, 1'b0, 0);
    run_scan(16'hFFFC, 16'hFFFF, 16'h0001, 8'd1, 1'b1, 1);

    // Start while busy is ignored; stop beats a simultaneous start.
    rdy_ctl = 3;
    @(posedge clk); #1;
    start_addr = 16'h0100; end_addr = 16'h01FF; stride = 16'd1; mode_wrap = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_addr = 16'h0500; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_addr", dump_addr, 16'h0100);
    chk("busy_start_busy", busy, 1);
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("stopstart_busy", busy, 0);
    chk("stopstart_valid", dump_valid, 0);
    chk("stopstart_done", done, 0);
    chk("stopstart_addr_hold", dump_addr, 16'h0100);
    repeat (2) @(negedge clk);
    chk("idle_stays_idle", busy, 0);

    // Back-to-back one-shot scans: the second starts from DONE.
    run_scan(16'h0200, 16'h0203, 16'h0001, 8'd0, 1'b0, 0);
    run_scan(16'h0300, 16'h0308, 16'h0004, 8'd2, 1'b0, 1);

    // Randomised windows.
    for (int i = 0; i < 14; i++) begin
      s = 16'($urandom);
      if ($urandom_range(0, 3) == 0) s = 16'hFFF0 | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0 && s != 0) e = s - 16'd1;
      else if (int'(s) + 30 > 65535) e = 16'hFFFF;
      else e = s + 16'($urandom_range(0, 30));
      run_scan(s, e, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
